// File: rtl/led_i2c_reg_sequencer.sv
// led_i2c_reg_sequencer: byte-level I2C transaction controller that decodes the
// device address and register pointer bytes, generates per-byte ACK/NACK and
// masters the LED register bus with single-cycle read/write strobes.
// Build option: define LED_I2C_AUTOINC_EN to take the auto-increment flag from
// bit 7 of the pointer byte; otherwise the pointer never advances.
module led_i2c_reg_sequencer #(
    parameter logic [6:0]  DEV_ADDR  = 7'h62,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_det,
    input  logic                 stop_det,
    input  logic                 rx_valid,
    input  logic [DATA_BITS-1:0] rx_byte,
    input  logic                 tx_ready,
    output logic                 ack_valid,
    output logic                 ack,
    output logic                 tx_valid,
    output logic [DATA_BITS-1:0] tx_byte,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic                 bus_r_en,
    output logic                 bus_w_en,
    inout  wire  [DATA_BITS-1:0] bus_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_ADDR,
        CTRL_REG,
        CTRL_DATA
    } ctrl_state_t;

    ctrl_state_t          state_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic [ADDR_BITS-1:0] ptr_d;
    logic [ADDR_BITS-1:0] bus_addr_q;
    logic                 ai_q;
    logic                 rw_q;
    logic                 ack_valid_q;
    logic                 ack_q;
    logic                 tx_valid_q;
    logic                 bus_r_en_q;
    logic                 bus_w_en_q;
    logic [DATA_BITS-1:0] tx_byte_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 addr_match;
    logic                 rsvd_clear;

    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
    // Reserved pointer bits sit between the register index and bit 7.
    assign rsvd_clear = ((rx_byte[6:0] >> ADDR_BITS) == 7'd0);

    // Pointer after the in-flight strobe's increment; a strobe issued in the same
    // cycle uses this so back-to-back bytes land on consecutive registers.
    always_comb begin
        ptr_d = ptr_q;
        if ((bus_w_en_q || bus_r_en_q) && ai_q) begin
            ptr_d = ptr_q + ADDR_BITS'(1);
        end
    end

    // Transaction FSM with registered bus strobes, ack and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CTRL_IDLE;
            ptr_q       <= '0;
            ai_q        <= 1'b0;
            rw_q        <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= '0;
            bus_addr_q  <= '0;
            bus_r_en_q  <= 1'b0;
            bus_w_en_q  <= 1'b0;
            wdata_q     <= '0;
        end else begin
            ack_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            bus_r_en_q  <= 1'b0;
            bus_w_en_q  <= 1'b0;
            tx_valid_q  <= bus_r_en_q;
            if (bus_r_en_q) begin
                tx_byte_q <= bus_data;
            end
            ptr_q <= ptr_d;

            if (stop_det) begin
                state_q <= CTRL_IDLE;
            end else if (start_det) begin
                state_q <= CTRL_ADDR;
            end else begin
                unique case (state_q)
                    CTRL_IDLE: begin
                        state_q <= CTRL_IDLE;
                    end
                    CTRL_ADDR: begin
                        if (rx_valid) begin
                            ack_valid_q <= 1'b1;
                            if (addr_match) begin
                                ack_q   <= 1'b1;
                                rw_q    <= rx_byte[0];
                                state_q <= rx_byte[0] ? CTRL_DATA : CTRL_REG;
                            end else begin
                                state_q <= CTRL_IDLE;
                            end
                        end
                    end
                    CTRL_REG: begin
                        if (rx_valid) begin
                            ack_valid_q <= 1'b1;
                            if (rsvd_clear) begin
                                ack_q   <= 1'b1;
                                ptr_q   <= rx_byte[ADDR_BITS-1:0];
`ifdef LED_I2C_AUTOINC_EN
                                ai_q    <= rx_byte[7];
`else
                                ai_q    <= 1'b0;
`endif
                                state_q <= CTRL_DATA;
                            end else begin
                                state_q <= CTRL_IDLE;
                            end
                        end
                    end
                    CTRL_DATA: begin
                        if (!rw_q) begin
                            if (rx_valid) begin
                                bus_w_en_q  <= 1'b1;
                                bus_addr_q  <= ptr_d;
                                wdata_q     <= rx_byte;
                                ack_valid_q <= 1'b1;
                                ack_q       <= 1'b1;
                            end
                        end else if (tx_ready && !bus_r_en_q) begin
                            bus_r_en_q <= 1'b1;
                            bus_addr_q <= ptr_d;
                        end
                    end
                    default: begin
                        state_q <= CTRL_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus_data  = bus_w_en_q ? wdata_q : 'z;
    assign ack_valid = ack_valid_q;
    assign ack       = ack_q;
    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;
    assign bus_addr  = bus_addr_q;
    assign bus_r_en  = bus_r_en_q;
    assign bus_w_en  = bus_w_en_q;
    assign busy      = (state_q != CTRL_IDLE);

endmodule

// File: tb/tb_led_i2c_reg_sequencer.sv
// Scoreboard bench for led_i2c_reg_sequencer: stimulus pushes expected acks,
// writes, read strobes and read data; a negedge monitor pops and compares.
module tb_led_i2c_reg_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_det = 1'b0;
    logic       stop_det = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_ready = 1'b0;
    logic       ack_valid;
    logic       ack;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic [2:0] bus_addr;
    logic       bus_r_en;
    logic       bus_w_en;
    logic       busy;
    wire  [7:0] bus_data;

    logic [7:0] regs [0:7];

    int n_checks = 0;
    int n_pass   = 0;

    logic        exp_ack [$];
    logic [10:0] exp_wr  [$];
    logic [2:0]  exp_rd  [$];
    logic [7:0]  exp_tx  [$];
    logic [10:0] mon_w;

    led_i2c_reg_sequencer #(
        .DEV_ADDR  (7'h62),
        .ADDR_BITS (3),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_det (start_det),
        .stop_det  (stop_det),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_ready  (tx_ready),
        .ack_valid (ack_valid),
        .ack       (ack),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .bus_addr  (bus_addr),
        .bus_r_en  (bus_r_en),
        .bus_w_en  (bus_w_en),
        .bus_data  (bus_data),
        .busy      (busy)
    );

    // Register-file slave: answers read strobes combinationally.
    assign bus_data = bus_r_en ? regs[bus_addr] : 'z;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
        tick();
    endtask

    task automatic do_stop();
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_ack(input logic [7:0] b, input logic a);
        exp_ack.push_back(a);
        send(b);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] d);
        exp_rd.push_back(a);
        exp_tx.push_back(d);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Monitor: every presented output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack_valid) begin
                if (exp_ack.size() == 0) chk("ack_unexpected", 32'(ack_valid), 32'd0);
                else chk("ack", 32'(ack), 32'(exp_ack.pop_front()));
            end
            if (bus_w_en || bus_r_en) chk("rw_exclusive", 32'(bus_w_en & bus_r_en), 32'd0);
            if (bus_w_en) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 32'(bus_w_en), 32'd0);
                else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus_addr), 32'(mon_w[10:8]));
                    chk("wr_data", 32'(bus_data), 32'(mon_w[7:0]));
                end
            end
            if (bus_r_en) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'(bus_r_en), 32'd0);
                else chk("rd_addr", 32'(bus_addr), 32'(exp_rd.pop_front()));
            end
            if (tx_valid) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_valid), 32'd0);
                else chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 + i);
        regs[7] = 8'hAA;
        regs[0] = 8'h55;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack_valid", 32'(ack_valid), 32'd0);
        chk("rst_w_en", 32'(bus_w_en), 32'd0);
        chk("rst_r_en", 32'(bus_r_en), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        reset = 1'b0;
        tick();

        // T1: single write to register 1
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        send_ack(8'hC4, 1'b1);
        send_ack(8'h01, 1'b1);
        exp_wr.push_back({3'd1, 8'h80});
        send_ack(8'h80, 1'b1);
        do_stop();
        chk("t1_idle", 32'(busy), 32'd0);

        // T2: wrong device address, then ignored bytes
        do_start();
        send_ack(8'hC6, 1'b0);
        chk("t2_idle", 32'(busy), 32'd0);
        send(8'h11);
        send(8'h22);

        // T3: back-to-back data bytes from pointer 6
        do_start();
        send_ack(8'hC4, 1'b1);
        send_ack(8'h86, 1'b1);
        for (int i = 0; i < 3; i++) exp_ack.push_back(1'b1);
`ifdef LED_I2C_AUTOINC_EN
        exp_wr.push_back({3'd6, 8'h11});
        exp_wr.push_back({3'd7, 8'h22});
        exp_wr.push_back({3'd0, 8'h33});
`else
        exp_wr.push_back({3'd6, 8'h11});
        exp_wr.push_back({3'd6, 8'h22});
        exp_wr.push_back({3'd6, 8'h33});
`endif
        rx_valid = 1'b1;
        rx_byte  = 8'h11;
        tick();
        rx_byte  = 8'h22;
        tick();
        rx_byte  = 8'h33;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        do_stop();

        // T4: set pointer 7, repeated start, two reads
        do_start();
        send_ack(8'hC4, 1'b1);
        send_ack(8'h87, 1'b1);
        do_start();
        chk("t4_busy", 32'(busy), 32'd1);
        send_ack(8'hC5, 1'b1);
        do_read(3'd7, 8'hAA);
`ifdef LED_I2C_AUTOINC_EN
        do_read(3'd0, 8'h55);
`else
        do_read(3'd7, 8'hAA);
`endif
        send(8'h00);
        do_stop();

        // T5: data byte loses to stop; reserved pointer bits NACK
        do_start();
        send_ack(8'hC4, 1'b1);
        send_ack(8'h01, 1'b1);
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        stop_det = 1'b1;
        tick();
        rx_valid = 1'b0;
        stop_det = 1'b0;
        tick();
        chk("t5_idle_stop", 32'(busy), 32'd0);
        do_start();
        send_ack(8'hC4, 1'b1);
        send_ack(8'h18, 1'b0);
        chk("t5_idle_nack", 32'(busy), 32'd0);

        // T6: reset lands on the cycle the write strobe would appear
        do_start();
        send_ack(8'hC4, 1'b1);
        send_ack(8'h02, 1'b1);
        rx_valid = 1'b1;
        rx_byte  = 8'h5A;
        tick();
        rx_valid = 1'b0;
        reset    = 1'b1;
        #2;
        chk("t6_w_en", 32'(bus_w_en), 32'd0);
        chk("t6_ack_valid", 32'(ack_valid), 32'd0);
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tx_byte", 32'(tx_byte), 32'd0);
        chk("t6_bus_addr", 32'(bus_addr), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Pointer returns to 0 after reset
        do_start();
        send_ack(8'hC5, 1'b1);
        do_read(3'd0, 8'h55);
        do_stop();

        repeat (4) tick();
        chk("end_ack_q", 32'(exp_ack.size()), 32'd0);
        chk("end_wr_q", 32'(exp_wr.size()), 32'd0);
        chk("end_rd_q", 32'(exp_rd.size()), 32'd0);
        chk("end_tx_q", 32'(exp_tx.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
